// File: rtl/pipeline_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline: opcodes, sequencer states, control bundle.
package pipeline_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_e;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_flush;
    logic pipe_stall;
  } pipe_ctrl_t;

  // Instructions whose rt field is a source operand rather than a destination.
  function automatic logic uses_rt(input logic [5:0] opcode);
    return (opcode == OP_RTYPE) || (opcode == OP_BEQ) || (opcode == OP_SW);
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector between the IF/ID and ID/EX instructions.
module load_use_detect
  import pipeline_pkg::*;
(
  input  logic [5:0] i_id_opcode,
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  input  logic       i_ex_mem_read,
  input  logic [4:0] i_ex_rt,
  output logic       o_load_use
);

  logic w_rs_hit;
  logic w_rt_hit;

  assign w_rs_hit   = (i_ex_rt == i_id_rs);
  assign w_rt_hit   = (i_ex_rt == i_id_rt) && uses_rt(i_id_opcode);
  // $zero is never a real dependency.
  assign o_load_use = i_ex_mem_read && (i_ex_rt != 5'd0) && (w_rs_hit || w_rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: load-use stalls, branch/jump squashes, memory wait states and timeout halt.
// Optional performance counters are built when HAZ_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [5:0]       i_id_opcode,
  input  logic [4:0]       i_id_rs,
  input  logic [4:0]       i_id_rt,
  input  logic             i_id_jump,
  input  logic             i_ex_mem_read,
  input  logic [4:0]       i_ex_rt,
  input  logic             i_ex_branch_tk,
  input  logic             i_mem_req,
  input  logic             i_mem_ready,
  output logic             o_pc_write,
  output logic             o_ifid_write,
  output logic             o_ifid_flush,
  output logic             o_idex_flush,
  output logic             o_pipe_stall,
  output logic             o_mem_timeout,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);

  localparam pipe_ctrl_t CTRL_DEFAULT = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
                                          idex_flush: 1'b0, pipe_stall: 1'b0};
  localparam pipe_ctrl_t CTRL_FREEZE  = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                          idex_flush: 1'b0, pipe_stall: 1'b1};
  localparam pipe_ctrl_t CTRL_RESET   = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1,
                                          idex_flush: 1'b1, pipe_stall: 1'b0};

  state_e            r_state;
  state_e            w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_cnt_nxt;
  logic              r_mem_timeout;
  logic              w_set_timeout;
  logic              w_apply_hazards;
  logic              w_load_use;
  pipe_ctrl_t        w_ctrl;

  load_use_detect u_load_use_detect (
    .i_id_opcode   (i_id_opcode),
    .i_id_rs       (i_id_rs),
    .i_id_rt       (i_id_rt),
    .i_ex_mem_read (i_ex_mem_read),
    .i_ex_rt       (i_ex_rt),
    .o_load_use    (w_load_use)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= ST_RUN;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_wait_cnt    <= w_wait_cnt_nxt;
      r_mem_timeout <= r_mem_timeout | w_set_timeout;
    end
  end

  always_comb begin
    w_ctrl          = CTRL_DEFAULT;
    w_state_nxt     = r_state;
    w_wait_cnt_nxt  = r_wait_cnt;
    w_set_timeout   = 1'b0;
    w_apply_hazards = 1'b0;

    case (r_state)
      ST_RUN: begin
        if (i_mem_req && !i_mem_ready) begin
          w_ctrl         = CTRL_FREEZE;
          w_state_nxt    = ST_MEM_WAIT;
          w_wait_cnt_nxt = WAIT_ONE;
        end else begin
          w_apply_hazards = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (i_mem_ready) begin
          w_apply_hazards = 1'b1;
          w_state_nxt     = ST_RUN;
          w_wait_cnt_nxt  = '0;
        end else begin
          w_ctrl         = CTRL_FREEZE;
          w_wait_cnt_nxt = r_wait_cnt + WAIT_ONE;
          if ((MEM_TIMEOUT != 0) && (r_wait_cnt == WAIT_LIMIT)) begin
            w_state_nxt   = ST_HALT;
            w_set_timeout = 1'b1;
          end
        end
      end
      ST_HALT: begin
        w_ctrl = CTRL_FREEZE;
      end
      default: begin
        w_state_nxt    = ST_RUN;
        w_wait_cnt_nxt = '0;
      end
    endcase

    // A taken branch squashes whatever hazard the younger ID instruction would raise.
    if (w_apply_hazards) begin
      if (i_ex_branch_tk) begin
        w_ctrl.ifid_flush = 1'b1;
        w_ctrl.idex_flush = 1'b1;
      end else if (w_load_use) begin
        w_ctrl.pc_write   = 1'b0;
        w_ctrl.ifid_write = 1'b0;
        w_ctrl.idex_flush = 1'b1;
      end else if (i_id_jump) begin
        w_ctrl.ifid_flush = 1'b1;
      end
    end

    if (i_reset) begin
      w_ctrl = CTRL_RESET;
    end
  end

  assign o_pc_write    = w_ctrl.pc_write;
  assign o_ifid_write  = w_ctrl.ifid_write;
  assign o_ifid_flush  = w_ctrl.ifid_flush;
  assign o_idex_flush  = w_ctrl.idex_flush;
  assign o_pipe_stall  = w_ctrl.pipe_stall;
  assign o_mem_timeout = r_mem_timeout;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // Saturating counters; reset cycles never count since the registers are held cleared.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!w_ctrl.pc_write && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if ((w_ctrl.ifid_flush || w_ctrl.idex_flush) && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;
`else
  assign o_stall_cnt = '0;
  assign o_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed vector table, corner sequences, random vs model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned TO      = 4;
  localparam int unsigned CW      = 8;
  localparam int          CNT_MAX = 255;
`ifdef HAZ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic [5:0]    id_opcode;
  logic [4:0]    id_rs, id_rt, ex_rt;
  logic          id_jump, ex_mem_read, ex_branch_tk, mem_req, mem_ready;
  logic          pc_write, ifid_write, ifid_flush, idex_flush, pipe_stall, mem_timeout;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int checks;
  int errors;

  // Reference model state: cycles spent waiting on memory (0 = running), halt and sticky error.
  int m_wait;
  bit m_halt;
  bit m_to;
  int m_stall;
  int m_flush;

  pipe_hazard_ctrl #(
    .MEM_TIMEOUT (TO),
    .CNT_W       (CW)
  ) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_id_opcode    (id_opcode),
    .i_id_rs        (id_rs),
    .i_id_rt        (id_rt),
    .i_id_jump      (id_jump),
    .i_ex_mem_read  (ex_mem_read),
    .i_ex_rt        (ex_rt),
    .i_ex_branch_tk (ex_branch_tk),
    .i_mem_req      (mem_req),
    .i_mem_ready    (mem_ready),
    .o_pc_write     (pc_write),
    .o_ifid_write   (ifid_write),
    .o_ifid_flush   (ifid_flush),
    .o_idex_flush   (idex_flush),
    .o_pipe_stall   (pipe_stall),
    .o_mem_timeout  (mem_timeout),
    .o_stall_cnt    (stall_cnt),
    .o_flush_cnt    (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       jump;
    logic       exmr;
    logic [4:0] exrt;
    logic       br;
    logic       mreq;
    logic       mrdy;
    logic [4:0] exp;   // {pc_write, ifid_write, ifid_flush, idex_flush, pipe_stall}
  } vec_t;

  vec_t tab[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected control outputs from the current model state and the present inputs.
  function automatic logic [4:0] model_ctrl();
    bit lu, frozen, src_rt;
    src_rt = (id_opcode == 6'b000000) || (id_opcode == 6'b000100) || (id_opcode == 6'b101011);
    lu = ex_mem_read && (ex_rt != 0) && ((ex_rt == id_rs) || ((ex_rt == id_rt) && src_rt));
    if (reset) return 5'b00110;
    if (m_halt) return 5'b00001;
    frozen = (m_wait > 0) ? !mem_ready : (mem_req && !mem_ready);
    if (frozen) return 5'b00001;
    if (ex_branch_tk) return 5'b11110;
    if (lu) return 5'b00010;
    if (id_jump) return 5'b11100;
    return 5'b11000;
  endfunction

  task automatic model_step(input logic [4:0] ctrl);
    if (reset) begin
      m_wait = 0; m_halt = 0; m_to = 0; m_stall = 0; m_flush = 0;
      return;
    end
    if (!ctrl[4] && m_stall < CNT_MAX) m_stall++;
    if ((ctrl[2] || ctrl[1]) && m_flush < CNT_MAX) m_flush++;
    if (m_halt) return;
    if (m_wait == 0) begin
      if (mem_req && !mem_ready) m_wait = 1;
    end else if (mem_ready) begin
      m_wait = 0;
    end else if (TO != 0 && m_wait == int'(TO)) begin
      m_halt = 1; m_to = 1;
    end else begin
      m_wait++;
    end
  endtask

  task automatic set_in(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic jump, input logic exmr, input logic [4:0] exrt,
                        input logic br, input logic mreq, input logic mrdy);
    id_opcode = op; id_rs = rs; id_rt = rt; id_jump = jump; ex_mem_read = exmr;
    ex_rt = exrt; ex_branch_tk = br; mem_req = mreq; mem_ready = mrdy;
  endtask

  // Called just after a falling edge with inputs driven; checks, then advances one clock.
  task automatic apply(input string name, input bit use_exp, input logic [4:0] exp_ctrl);
    logic [4:0] mexp;
    #1;
    mexp = model_ctrl();
    check({name, " ctrl"}, {27'd0, pc_write, ifid_write, ifid_flush, idex_flush, pipe_stall},
          {27'd0, (use_exp ? exp_ctrl : mexp)});
    check({name, " timeout"}, {31'd0, mem_timeout}, {31'd0, (reset ? 1'b0 : m_to)});
    check({name, " stall_cnt"}, {24'd0, stall_cnt}, (PERF && !reset) ? m_stall : 0);
    check({name, " flush_cnt"}, {24'd0, flush_cnt}, (PERF && !reset) ? m_flush : 0);
    model_step(mexp);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    set_in(6'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    apply("reset", 1'b1, 5'b00110);
    reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_wait = 0; m_halt = 0; m_to = 0; m_stall = 0; m_flush = 0;
    reset  = 1'b1;
    set_in(6'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);

    tab[0]  = '{6'b000000, 5'd8, 5'd3, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 5'b00010};
    tab[1]  = '{6'b000000, 5'd8, 5'd3, 1'b0, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, 5'b11000};
    tab[2]  = '{6'b000000, 5'd0, 5'd5, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'b11000};
    tab[3]  = '{6'b100011, 5'd1, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 5'b11000};
    tab[4]  = '{6'b101011, 5'd1, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 5'b00010};
    tab[5]  = '{6'b000100, 5'd1, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 5'b00010};
    tab[6]  = '{6'b000000, 5'd8, 5'd3, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 5'b11110};
    tab[7]  = '{6'b000000, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b11100};
    tab[8]  = '{6'b000000, 5'd8, 5'd3, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 5'b00010};
    tab[9]  = '{6'b000000, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'b11000};
    tab[10] = '{6'b000000, 5'd1, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 5'b00010};
    tab[11] = '{6'b000010, 5'd1, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 5'b11000};
    tab[12] = '{6'b101011, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'b11000};
    tab[13] = '{6'b000000, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 5'b11110};

    @(negedge clk);
    do_reset();

    foreach (tab[i]) begin
      set_in(tab[i].op, tab[i].rs, tab[i].rt, tab[i].jump, tab[i].exmr, tab[i].exrt,
             tab[i].br, tab[i].mreq, tab[i].mrdy);
      apply($sformatf("vec%0d", i), 1'b1, tab[i].exp);
    end

    // Memory wait of three cycles, released on the fourth.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(6'd0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      apply($sformatf("memwait%0d", i), 1'b1, 5'b00001);
    end
    set_in(6'd0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    apply("memrelease", 1'b1, 5'b11000);
    check("memwait stall_cnt", {24'd0, stall_cnt}, PERF ? 3 : 0);
    set_in(6'd0, 5'd8, 5'd3, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
    apply("back_in_run", 1'b1, 5'b00010);

    // Jump flush counting.
    do_reset();
    set_in(6'd0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    apply("jump", 1'b1, 5'b11100);
    check("jump flush_cnt", {24'd0, flush_cnt}, PERF ? 1 : 0);

    // Branch during a freeze is held off until release.
    do_reset();
    set_in(6'd0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    apply("br_frozen", 1'b1, 5'b00001);
    set_in(6'd0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
    apply("br_release", 1'b1, 5'b11110);

    // Timeout: one RUN cycle plus TO wait cycles, then HALT.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_in(6'd0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      apply($sformatf("to_wait%0d", i), 1'b1, 5'b00001);
      if (i == 3) check("timeout not yet", {31'd0, mem_timeout}, 32'd0);
    end
    check("timeout set", {31'd0, mem_timeout}, 32'd1);
    set_in(6'd0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
    apply("halt0", 1'b1, 5'b00001);
    apply("halt1", 1'b1, 5'b00001);
    check("timeout sticky", {31'd0, mem_timeout}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_halt reset ctrl", {27'd0, pc_write, ifid_write, ifid_flush, idex_flush,
          pipe_stall}, {27'd0, 5'b00110});
    check("mid_halt reset timeout", {31'd0, mem_timeout}, 32'd0);
    model_step(5'b00110);
    @(negedge clk);
    reset = 1'b0;
    set_in(6'd0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    apply("after_halt", 1'b1, 5'b11000);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      logic [5:0] op;
      case ($urandom_range(0, 5))
        0: op = 6'b000000;
        1: op = 6'b100011;
        2: op = 6'b101011;
        3: op = 6'b000100;
        4: op = 6'b000010;
        default: op = 6'($urandom);
      endcase
      reset = ($urandom_range(0, 59) == 0);
      set_in(op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             ($urandom_range(0, 5) == 0), 1'($urandom), 5'($urandom_range(0, 3)),
             ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 9) < 4));
      apply("rand", 1'b0, 5'b00000);
      reset = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
